// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding req/ack fetch on the instruction bus,
// buffers the returned word and hands it to ID through a registered IF/ID boundary.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold,
        StDrop
    } state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] pc_buf_q, pc_buf_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic        if_hold;
    logic        id_hold;
    logic        handoff;

    // Only the IF/ID and ID hold bits matter to this stage.
    logic        unused_stall;
    assign unused_stall = ^{stall_i[5:3], stall_i[0]};

    assign if_hold = stall_i[1];
    assign id_hold = stall_i[2];
    assign handoff = (state_q == StHold) && !if_hold;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pc_buf_d   = pc_buf_q;
        inst_buf_d = inst_buf_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;

        if (flush_i) begin
            id_pc_d   = '0;
            id_inst_d = '0;
            unique case (state_q)
                StIdle: state_d = StIdle;
                StWait: begin
                    // A request is never withdrawn before its ack, so an unacked
                    // fetch has to drain through DROP.
                    if (mem_ack_i) begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        state_d = StDrop;
                    end
                end
                StHold: state_d = StIdle;
                StDrop: begin
                    if (mem_ack_i) begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ce_i) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_i;
                        state_d    = StWait;
                    end
                end
                StWait: begin
                    if (mem_ack_i) begin
                        inst_buf_d = mem_data_i;
                        pc_buf_d   = mem_addr_q;
                        mem_req_d  = 1'b0;
                        state_d    = StHold;
                    end
                end
                StHold: begin
                    if (!if_hold) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (mem_ack_i) begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (handoff) begin
                id_pc_d   = pc_buf_q;
                id_inst_d = inst_buf_q;
            end else if (if_hold && id_hold) begin
                id_pc_d   = id_pc_q;
                id_inst_d = id_inst_q;
            end else begin
                // IF/ID stalled alone, or nothing ready: push a bubble into ID.
                id_pc_d   = '0;
                id_inst_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pc_buf_q   <= '0;
            inst_buf_q <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pc_buf_q   <= pc_buf_d;
            inst_buf_q <= inst_buf_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    // Low in HOLD so the PC register advances on the same edge as the handoff.
    assign stallreq_o = rst && ce_i && (state_q != StHold);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: hand-computed expectations for fetch timing,
// wait states, IF/ID stalls, flush and reset.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_fails  = 0;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: issue a zero-wait fetch and stop in HOLD.
    task automatic fetch_to_hold(input logic [31:0] pc, input logic [31:0] data);
        pc_i = pc;
        tick();
        check("fz_req", {31'b0, mem_req_o}, 32'd1);
        check("fz_addr", mem_addr_o, pc);
        mem_ack_i  = 1'b1;
        mem_data_i = data;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        check("fz_hold_req", {31'b0, mem_req_o}, 32'd0);
        check("fz_hold_stallreq", {31'b0, stallreq_o}, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        pc_i       = '0;
        ce_i       = 1'b1;
        stall_i    = '0;
        flush_i    = 1'b0;
        mem_ack_i  = 1'b1;   // stray ack during reset
        mem_data_i = 32'hBAD0_BAD0;

        // Reset values
        tick();
        tick();
        check("rst_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_id_pc", id_pc_o, 32'd0);
        check("rst_id_inst", id_inst_o, 32'd0);
        check("rst_stallreq", {31'b0, stallreq_o}, 32'd0);

        rst        = 1'b1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        check("idle_stallreq", {31'b0, stallreq_o}, 32'd1);

        // Zero-wait memory, pc 0,4,8 -> one pair every 3 cycles
        for (int k = 0; k < 3; k++) begin
            fetch_to_hold(32'(4 * k), 32'h100 + 32'(4 * k));
            check("zw_bubble_in_hold", id_inst_o, 32'd0);
            tick();
            check("zw_id_pc", id_pc_o, 32'(4 * k));
            check("zw_id_inst", id_inst_o, 32'h100 + 32'(4 * k));
            check("zw_idle_req", {31'b0, mem_req_o}, 32'd0);
        end

        // 3 wait states at 0x40: request held for 4 cycles
        pc_i = 32'h40;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (w == 3) begin
                mem_ack_i  = 1'b1;
                mem_data_i = 32'h1234_5678;
            end
            pc_i = 32'h44;   // address must stay latched
            #1;
            check("w3_req", {31'b0, mem_req_o}, 32'd1);
            check("w3_addr", mem_addr_o, 32'h40);
            check("w3_stallreq", {31'b0, stallreq_o}, 32'd1);
            check("w3_id_inst", id_inst_o, 32'd0);
        end
        tick();
        mem_ack_i = 1'b0;
        check("w3_hold_id", id_inst_o, 32'd0);
        tick();
        check("w3_id_pc", id_pc_o, 32'h40);
        check("w3_id_inst", id_inst_o, 32'h1234_5678);

        // Full IF/ID + ID stall: ID holds, buffer retained
        fetch_to_hold(32'h80, 32'hAAAA_0080);
        tick();
        check("sh_a_inst", id_inst_o, 32'hAAAA_0080);
        stall_i = 6'b000111;
        pc_i    = 32'h84;
        tick();
        check("sh_wait_inst", id_inst_o, 32'hAAAA_0080);
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hBBBB_0084;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        for (int s = 0; s < 3; s++) begin
            check("sh_hold_pc", id_pc_o, 32'h80);
            check("sh_hold_inst", id_inst_o, 32'hAAAA_0080);
            tick();
        end
        stall_i = '0;
        #1;
        check("sh_hold_stallreq", {31'b0, stallreq_o}, 32'd0);
        tick();
        check("sh_rel_pc", id_pc_o, 32'h84);
        check("sh_rel_inst", id_inst_o, 32'hBBBB_0084);

        // IF/ID stall alone: bubbles into ID, buffer kept
        stall_i = 6'b000011;
        pc_i    = 32'h88;
        tick();
        check("sb_wait_bubble", id_inst_o, 32'd0);
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hCCCC_0088;
        tick();
        mem_ack_i  = 1'b0;
        check("sb_hold_bubble0", id_inst_o, 32'd0);
        tick();
        check("sb_hold_bubble1", id_inst_o, 32'd0);
        check("sb_hold_req", {31'b0, mem_req_o}, 32'd0);
        stall_i = '0;
        tick();
        check("sb_rel_pc", id_pc_o, 32'h88);
        check("sb_rel_inst", id_inst_o, 32'hCCCC_0088);

        // Flush in WAIT without ack -> DROP until ack, data discarded
        pc_i = 32'hC0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_drop_req", {31'b0, mem_req_o}, 32'd1);
        check("fl_drop_inst", id_inst_o, 32'd0);
        check("fl_drop_stallreq", {31'b0, stallreq_o}, 32'd1);
        tick();
        check("fl_drop_req2", {31'b0, mem_req_o}, 32'd1);
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        check("fl_idle_req", {31'b0, mem_req_o}, 32'd0);
        check("fl_idle_inst", id_inst_o, 32'd0);
        fetch_to_hold(32'h200, 32'h300);
        check("fl_hold_inst", id_inst_o, 32'd0);
        tick();
        check("fl_next_pc", id_pc_o, 32'h200);
        check("fl_next_inst", id_inst_o, 32'h300);

        // Flush in HOLD: buffer discarded, back to IDLE, next fetch issues
        fetch_to_hold(32'h210, 32'h5555_0210);
        flush_i = 1'b1;
        pc_i    = 32'h214;
        tick();
        flush_i = 1'b0;
        check("fh_idle_req", {31'b0, mem_req_o}, 32'd0);
        check("fh_id_inst", id_inst_o, 32'd0);
        tick();
        check("fh_reissue_addr", mem_addr_o, 32'h214);
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h6666_0214;
        tick();
        mem_ack_i = 1'b0;
        tick();
        check("fh_next_inst", id_inst_o, 32'h6666_0214);

        // Reset mid-WAIT, then a stray ack in IDLE is ignored
        pc_i = 32'h300;
        tick();
        check("rw_req", {31'b0, mem_req_o}, 32'd1);
        rst = 1'b0;
        tick();
        check("rw_req0", {31'b0, mem_req_o}, 32'd0);
        check("rw_addr0", mem_addr_o, 32'd0);
        check("rw_id_pc0", id_pc_o, 32'd0);
        check("rw_id_inst0", id_inst_o, 32'd0);
        check("rw_stallreq0", {31'b0, stallreq_o}, 32'd0);
        rst        = 1'b1;
        ce_i       = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h7777_7777;
        tick();
        check("stray_req", {31'b0, mem_req_o}, 32'd0);
        check("stray_stallreq", {31'b0, stallreq_o}, 32'd0);
        tick();
        mem_ack_i = 1'b0;
        check("stray_id_inst", id_inst_o, 32'd0);
        check("stray_id_pc", id_pc_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly downstream of the PC register and upstream of the decode stage. Takes the PC/CE pair, runs a single-outstanding request/acknowledge transaction on the instruction memory bus with arbitrary wait states, and buffers the returned word. Presents the fetched instruction and its PC to the ID stage through a registered IF/ID boundary. Raises a stall request to the pipeline controller while no instruction is ready, and discards in-flight fetches on flush.

## Interface
- No parameters. Address and instruction buses are 32 bits (`InstAddrBus`, `InstBus`).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (`RstEnable` = 1'b0).
- pc_i  in  32  fetch address from the PC register.
- ce_i  in  1  fetch enable from the PC register; 0 means no fetch is issued.
- stall_i  in  6  pipeline stall vector; bit 1 = IF/ID hold, bit 2 = ID hold (1 = `Stop`).
- flush_i  in  1  discard all IF work and bubble the ID stage.
- mem_req_o  out  1  instruction bus request, registered.
- mem_addr_o  out  32  instruction bus address, registered, stable while mem_req_o=1.
- mem_ack_i  in  1  bus acknowledge; mem_data_i valid in the same cycle.
- mem_data_i  in  32  instruction word.
- id_pc_o  out  32  PC of the instruction in ID, registered.
- id_inst_o  out  32  instruction in ID, registered; 0 = bubble (NOP).
- stallreq_o  out  1  combinational stall request to the controller.

## Operation
- States: IDLE, WAIT, HOLD, DROP. Internal buffers pc_buf, inst_buf (32 each).
- IDLE: mem_req_o=0. If ce_i=1 and flush_i=0 -> mem_req_o<=1, mem_addr_o<=pc_i, go WAIT. Otherwise remain.
- WAIT: mem_req_o=1, mem_addr_o held. When mem_ack_i=1 -> inst_buf<=mem_data_i, pc_buf<=mem_addr_o, mem_req_o<=0, go HOLD.
- HOLD: buffer valid. When stall_i[1]=0 -> id_pc_o<=pc_buf, id_inst_o<=inst_buf, go IDLE. Otherwise remain.
- DROP: mem_req_o stays 1, because a request is never withdrawn before ack. When mem_ack_i=1 -> mem_req_o<=0, data discarded, go IDLE.
- stallreq_o = ce_i & (state != HOLD), and is 0 while rst=0. The PC register therefore advances on the same edge that HOLD hands off to ID.
- ID register update when not handing off:
  - stall_i[1]=1 and stall_i[2]=0 -> zeros (bubble).
  - stall_i[1]=1 and stall_i[2]=1 -> hold.
  - stall_i[1]=0 and state != HOLD -> zeros.
- Priority: rst > flush_i > stall_i > normal flow.
- flush_i=1 at an edge: id_pc_o<=0 and id_inst_o<=0, plus the following per state:
  - IDLE: no issue.
  - WAIT with ack in that cycle: go IDLE.
  - WAIT without ack: go DROP.
  - HOLD: buffer discarded, go IDLE.
  - DROP: remain until ack.
- ce_i=0 in any state other than IDLE does not abort the transaction; only rst or flush_i end it.

## Timing
- Reset values: state=IDLE, mem_req_o=0, mem_addr_o=0, id_pc_o=0, id_inst_o=0, buffers=0, stallreq_o=0. An ack arriving during or after reset with no request outstanding is ignored.
- Zero-wait memory (ack in the first WAIT cycle), one instruction every 3 cycles:
  - cycle 0: IDLE issues.
  - cycle 1: WAIT, ack.
  - cycle 2: HOLD hands off; the word is visible on id_*_o in cycle 3.
- N wait states add N cycles. stallreq_o is high in IDLE (ce_i=1), WAIT and DROP.
- mem_ack_i is sampled only while mem_req_o=1. An ack while mem_req_o=0 is ignored.

## Test plan
- Zero-wait memory returning addr+0x100, pc_i stepping 0,4,8 -> id_pc_o/id_inst_o = 0/0x100, 4/0x104, 8/0x108, one new pair every 3 cycles.
- 3-wait memory at pc_i=0x40 -> mem_req_o=1 with mem_addr_o=0x40 for 4 cycles and stallreq_o=1 throughout; the word appears on id_inst_o 2 cycles after ack.
- In HOLD, stall_i=6'b000111 for 5 cycles -> id outputs hold and buffer retained. On release, the buffered word enters ID on the next edge.
- In HOLD, stall_i=6'b000011 -> id_inst_o=0 (bubble) each stalled cycle, no buffer loss.
- flush_i pulse in WAIT, ack 2 cycles later with 0xDEADBEEF -> state DROP, mem_req_o held until ack, id_inst_o=0, 0xDEADBEEF never reaches ID. The next fetch uses the current pc_i.
- rst=0 for one cycle mid-WAIT -> next edge: mem_req_o=0, all outputs 0, IDLE. A subsequent stray ack is ignored.
